// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and op-type encodings for the vector memory sequencer
package vec_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SCALAR = 2'b00;
    localparam logic [1:0] OP_VECTOR = 2'b01;

endpackage

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - turns one scalar/vector load/store into a byte burst on a 1-cycle-latency RAM
module vector_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    input  logic [1:0]          op_type_i,
    input  logic                we_i,
    input  logic [A-1:0]        address_i,
    input  logic [I-1:0][L-1:0] vector_i,
    input  logic [L-1:0]        scalar_i,
    output logic [I-1:0][L-1:0] vector_o,
    output logic [L-1:0]        scalar_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [A-1:0]        mem_address_o,
    output logic [L-1:0]        mem_wdata_o,
    output logic                mem_we_o,
    input  logic [L-1:0]        mem_rdata_i
);

    localparam int IW = $clog2(I + 1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic [1:0]          op_q;
    logic                we_q;
    logic [A-1:0]        base_q;
    logic [I-1:0][L-1:0] vdata_q;
    logic [L-1:0]        sdata_q;
    logic [I-1:0][L-1:0] gather_q;
    logic [A-1:0]        addr_q;
    logic [L-1:0]        wdata_q;

    logic                is_vec;
    logic                last;
    logic [A-1:0]        cur_addr;
    logic [L-1:0]        cur_wdata;
    logic [I-1:0][L-1:0] gathered;

    // Per-beat address/data and the completed gather image including the final byte
    always_comb begin
        is_vec    = (op_q == OP_VECTOR);
        last      = is_vec ? (idx == IW'(I - 1)) : (idx == '0);
        cur_addr  = base_q + A'(idx);
        cur_wdata = is_vec ? vdata_q[idx] : sdata_q;
        gathered  = gather_q;
        gathered[I-1] = mem_rdata_i;
    end

    // RAM drive: live during ISSUE, otherwise hold the last beat with writes disabled
    always_comb begin
        mem_we_o      = (state == ISSUE) && we_q;
        mem_address_o = (state == ISSUE) ? cur_addr : addr_q;
        mem_wdata_o   = ((state == ISSUE) && we_q) ? cur_wdata : wdata_q;
    end

    // Sequencer FSM: latch request, walk the bytes, gather load data, pulse done
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            idx      <= '0;
            op_q     <= '0;
            we_q     <= 1'b0;
            base_q   <= '0;
            vdata_q  <= '0;
            sdata_q  <= '0;
            gather_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            vector_o <= '0;
            scalar_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q    <= op_type_i;
                        we_q    <= we_i;
                        base_q  <= address_i;
                        vdata_q <= vector_i;
                        sdata_q <= scalar_i;
                        idx     <= '0;
                        busy_o  <= 1'b1;
                        if (op_type_i == OP_SCALAR || op_type_i == OP_VECTOR) begin
                            state <= ISSUE;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    addr_q <= cur_addr;
                    if (we_q) begin
                        wdata_q <= cur_wdata;
                    end else if (idx != '0) begin
                        // read data lags its address by one beat
                        gather_q[idx - IW'(1)] <= mem_rdata_i;
                    end
                    idx <= idx + IW'(1);
                    if (last) begin
                        if (we_q) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (is_vec) begin
                        vector_o <= gathered;
                    end else begin
                        scalar_o <= mem_rdata_i;
                    end
                    state  <= DONE;
                    done_o <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - scoreboard bench for vector_mem_sequencer
module tb_vector_mem_sequencer;

    localparam int I = 20;
    localparam int L = 8;
    localparam int A = 32;
    localparam int W = I * L;

    typedef logic [I-1:0][L-1:0] vec_t;
    typedef struct {
        int unsigned done_cyc;
        vec_t        vec;
        logic [L-1:0] sc;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    op_type_i = '0;
    logic          we_i = 1'b0;
    logic [A-1:0]  address_i = '0;
    vec_t          vector_i = '0;
    logic [L-1:0]  scalar_i = '0;
    vec_t          vector_o;
    logic [L-1:0]  scalar_o;
    logic          busy_o;
    logic          done_o;
    logic [A-1:0]  mem_address_o;
    logic [L-1:0]  mem_wdata_o;
    logic          mem_we_o;
    logic [L-1:0]  mem_rdata_i = '0;

    vector_mem_sequencer #(.I(I), .L(L), .A(A)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .op_type_i(op_type_i), .we_i(we_i),
        .address_i(address_i), .vector_i(vector_i), .scalar_i(scalar_i),
        .vector_o(vector_o), .scalar_o(scalar_o), .busy_o(busy_o), .done_o(done_o),
        .mem_address_o(mem_address_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Environment RAM: synchronous, one-cycle read latency
    bit [L-1:0] ram [bit [A-1:0]];
    always @(posedge CLK) begin
        if (mem_we_o) ram[mem_address_o] = mem_wdata_o;
        mem_rdata_i <= ram.exists(mem_address_o) ? ram[mem_address_o] : '0;
    end

    // Reference model state
    bit [L-1:0] ref_mem [bit [A-1:0]];
    vec_t         m_vec = '0;
    logic [L-1:0] m_sc = '0;
    exp_t         exp_q[$];
    bit           no_write = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < I; k++) v[k] = L'($urandom);
        return v;
    endfunction

    function automatic bit [L-1:0] ref_rd(input logic [A-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Expected outcome of one request computed from the access rules
    task automatic model(input logic [1:0] op, input logic we, input logic [A-1:0] addr,
                         input vec_t v, input logic [L-1:0] sc, input int unsigned s,
                         output int lat);
        exp_t e;
        logic [A-1:0] a;
        if (op == 2'b00) begin
            if (we) begin ref_mem[addr] = sc; lat = 2; end
            else begin m_sc = ref_rd(addr); lat = 3; end
        end else if (op == 2'b01) begin
            for (int k = 0; k < I; k++) begin
                a = addr + A'(k);
                if (we) ref_mem[a] = v[k];
                else m_vec[k] = ref_rd(a);
            end
            lat = we ? I + 1 : I + 2;
        end else begin
            lat = 1;
        end
        e.done_cyc = s + int'(lat) - 1;
        e.vec = m_vec;
        e.sc = m_sc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic we, input logic [A-1:0] addr,
                         input vec_t v, input logic [L-1:0] sc, input bit hold);
        int lat, lat2, n;
        start_i = 1'b1; op_type_i = op; we_i = we; address_i = addr; vector_i = v; scalar_i = sc;
        no_write = op[1] || !we;
        model(op, we, addr, v, sc, cyc + 1, lat);
        @(negedge CLK);
        start_i   = hold;
        address_i = $urandom;
        vector_i  = rand_vec();
        scalar_i  = L'($urandom);
        we_i      = 1'($urandom);
        op_type_i = hold ? 2'b11 : 2'($urandom);
        wait_idle(n);
        check("busy_cycles", W'(n), W'(lat));
        if (hold) begin
            // held strobe is sampled in the IDLE cycle after DONE, with whatever is on the inputs now
            model(2'b11, 1'b0, '0, '0, '0, cyc + 1, lat2);
            no_write = 1'b1;
            @(negedge CLK);
            start_i = 1'b0;
            wait_idle(n);
            check("held_start_busy", W'(n), W'(lat2));
        end
        no_write = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && no_write) check("no_ram_write", W'(mem_we_o), W'(0));
        if (RST && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", W'(exp_q.size()), W'(1));
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", W'(cyc), W'(e.done_cyc));
                check("vector_o", W'(vector_o), W'(e.vec));
                check("scalar_o", W'(scalar_o), W'(e.sc));
            end
        end
    end

    initial begin
        vec_t v;
        int miss;
        logic [A-1:0] a;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", W'(busy_o), W'(0));
        check("rst_done", W'(done_o), W'(0));
        check("rst_we", W'(mem_we_o), W'(0));
        check("rst_addr", W'(mem_address_o), W'(0));
        check("rst_vector", W'(vector_o), W'(0));
        check("rst_scalar", W'(scalar_o), W'(0));
        RST = 1'b1;
        @(negedge CLK);

        // Reset in the middle of a vector store, while element 7 is on the bus
        v = rand_vec();
        start_i = 1'b1; op_type_i = 2'b01; we_i = 1'b1; address_i = 32'h200; vector_i = v;
        @(negedge CLK);
        start_i = 1'b0;
        repeat (7) @(negedge CLK);
        check("pre_reset_we", W'(mem_we_o), W'(1));
        check("pre_reset_addr", W'(mem_address_o), W'(32'h207));
        RST = 1'b0;
        #1;
        check("async_rst_we", W'(mem_we_o), W'(0));
        check("async_rst_busy", W'(busy_o), W'(0));
        check("async_rst_addr", W'(mem_address_o), W'(0));
        for (int k = 0; k < 7; k++) ref_mem[32'h200 + A'(k)] = v[k];
        m_vec = '0;
        m_sc = '0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        miss = 0;
        for (int k = 7; k < I; k++) if (ram.exists(32'h200 + A'(k))) miss++;
        check("untouched_after_reset", W'(miss), W'(0));

        // Vector store then load of the same region
        for (int k = 0; k < I; k++) v[k] = L'(k + 1);
        do_op(2'b01, 1'b1, 32'h100, v, 8'h00, 1'b0);
        miss = 0;
        for (int k = 0; k < I; k++) begin
            a = 32'h100 + A'(k);
            if (!ram.exists(a) || ram[a] != L'(k + 1)) miss++;
        end
        check("ram_0x100_image", W'(miss), W'(0));
        do_op(2'b01, 1'b0, 32'h100, rand_vec(), L'($urandom), 1'b0);

        // Scalar store/load
        do_op(2'b00, 1'b1, 32'h3FF, rand_vec(), 8'hA5, 1'b0);
        do_op(2'b00, 1'b0, 32'h3FF, rand_vec(), 8'h00, 1'b0);
        check("scalar_a5", W'(scalar_o), W'(8'hA5));

        // Address wrap across 2^A
        do_op(2'b01, 1'b1, 32'hFFFF_FFF0, rand_vec(), 8'h00, 1'b0);
        miss = 0;
        for (int k = 0; k < 4; k++) if (!ram.exists(A'(k))) miss++;
        check("wrap_low_bytes", W'(miss), W'(0));
        do_op(2'b01, 1'b0, 32'hFFFF_FFF0, rand_vec(), 8'h00, 1'b0);

        // No-op with write enable set
        do_op(2'b11, 1'b1, 32'h40, rand_vec(), 8'h77, 1'b0);
        do_op(2'b10, 1'b0, 32'h40, rand_vec(), 8'h77, 1'b0);

        // Strobe held through a whole store, inputs changing mid-burst
        do_op(2'b01, 1'b1, 32'h300, rand_vec(), 8'h00, 1'b1);

        // Randomized mix over a few overlapping regions
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: a = 32'h100;
                1: a = 32'h3F0;
                default: a = 32'hFFFF_FFE0;
            endcase
            a = a + A'($urandom_range(0, 40));
            do_op(2'($urandom_range(0, 3)), 1'($urandom), a, rand_vec(), L'($urandom), 1'b0);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        check("ram_size", W'(ram.num()), W'(ref_mem.num()));
        miss = 0;
        foreach (ref_mem[k]) if (!ram.exists(k) || ram[k] != ref_mem[k]) miss++;
        check("ram_contents", W'(miss), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
